// File: rtl/interpolate.sv
// interpolate: upsampler by an integer factor L with valid/ready handshakes.
// Each accepted input sample is expanded into L output samples. Phase 0
// carries the sample itself; phases 1..L-1 carry zeros (zero-stuffing) or,
// when INTERPOLATE_HOLD_EN is defined, repeat the sample (zero-order hold).
// Handshake and timing behaviour is identical in both builds.
//
// Parameters:
//   W  sample width in bits
//   L  interpolation factor (output samples per input sample), L >= 2
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   s_stb    slave sample valid
//   s_dat    slave sample data
//   s_rdy    slave ready (transfer on s_stb & s_rdy)
//   m_rdy    master ready
//   m_stb    master sample valid (transfer on m_stb & m_rdy)
//   m_dat    master sample data
//   m_first  current master sample is phase 0 of its input sample
// Build option: define INTERPOLATE_HOLD_EN for zero-order hold output.
module interpolate #(
  parameter int unsigned W = 16,
  parameter int unsigned L = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_stb,
  input  logic [W-1:0] s_dat,
  output logic         s_rdy,
  input  logic         m_rdy,
  output logic         m_stb,
  output logic [W-1:0] m_dat,
  output logic         m_first
);

  localparam int unsigned PHS_W = (L > 2) ? $clog2(L) : 1;
  localparam logic [PHS_W-1:0] PHS_LAST = PHS_W'(L - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     dat_q, dat_d;
  logic [PHS_W-1:0] phs_q, phs_d;

  // State, sample and phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dat_q   <= '0;
      phs_q   <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      phs_q   <= phs_d;
    end
  end

  // Next state and handshakes; the last phase may accept a new sample in the
  // same cycle it is consumed, so streaming needs no bubble.
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    phs_d   = phs_q;
    s_rdy   = 1'b0;
    m_stb   = 1'b0;
    case (state_q)
      IDLE: begin
        s_rdy = 1'b1;
        if (s_stb) begin
          dat_d   = s_dat;
          phs_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        m_stb = 1'b1;
        s_rdy = (phs_q == PHS_LAST) && m_rdy;
        if (m_rdy) begin
          if (phs_q != PHS_LAST) begin
            phs_d = phs_q + PHS_W'(1);
          end else if (s_stb) begin
            dat_d = s_dat;
            phs_d = '0;
          end else begin
            phs_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        phs_d   = '0;
      end
    endcase
    // Nothing is offered or accepted while reset is held.
    if (rst) begin
      s_rdy = 1'b0;
      m_stb = 1'b0;
    end
  end

  // Output data selection by phase.
  always_comb begin
    m_first = m_stb && (phs_q == '0);
`ifdef INTERPOLATE_HOLD_EN
    m_dat = dat_q;
`else
    m_dat = (phs_q == '0) ? dat_q : '0;
`endif
  end

endmodule
